// File: rtl/vector_rename_unit.sv
// vector_rename_unit
//   Register rename stage between the vector decoder and the VRF address
//   generators. Maps architectural vector registers (LMUL groups of 1/2/4/8)
//   onto a physical register pool. Destinations get fresh physical registers
//   from a free list, and registers freed at commit are returned to it.
//
// Ports
//   clk, rstn                    clock, async active-low reset
//   instr_vld_i / instr_rdy_o    instruction handshake
//   vs1_i, vs2_i, vd_i           architectural base registers
//   lmul_i                       log2 of group size N
//   vd_wr_i                      instruction writes vd
//   vrf_starting_addr_vld_o/rdy_i  result handshake
//   vrf_starting_raddr0_o/raddr1_o/waddr_o  8 slots of AW bits; slot k = group member k
//   old_preg_o                   8 slots of PW bits, previous mapping of vd+k
//   free_vld_i, free_preg_i      return one physical register per cycle
//   free_cnt_o                   free-list occupancy
//   free_err_o                   one-cycle pulse when a push into a full list is dropped
//
// Configuration macro
//   RENAME_BYPASS_EN : identity mapping, no allocation, free list disabled.
//
// FSM states
//   state   | meaning
//   S_IDLE  | ready for a new instruction; fields latched on accept
//   S_READ  | capture source mappings and old vd mappings
//   S_ALLOC | pop one free preg per cycle into map[vd+k]; stall while empty
//   S_OUT   | present buses until the consumer takes them

module vector_rename_unit #(
  parameter int VLEN         = 4096,
  parameter int VLANE_NUM    = 8,
  parameter int PHYS_REG_NUM = 48,
  localparam int LP_VECTOR_REG_SIZE = VLEN / 32 / VLANE_NUM,
  localparam int PW = $clog2(PHYS_REG_NUM),
  localparam int AW = $clog2(PHYS_REG_NUM * LP_VECTOR_REG_SIZE)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            instr_vld_i,
  output logic            instr_rdy_o,
  input  logic [4:0]      vs1_i,
  input  logic [4:0]      vs2_i,
  input  logic [4:0]      vd_i,
  input  logic [1:0]      lmul_i,
  input  logic            vd_wr_i,
  output logic            vrf_starting_addr_vld_o,
  input  logic            vrf_starting_addr_rdy_i,
  output logic [8*AW-1:0] vrf_starting_raddr0_o,
  output logic [8*AW-1:0] vrf_starting_raddr1_o,
  output logic [8*AW-1:0] vrf_starting_waddr_o,
  output logic [8*PW-1:0] old_preg_o,
  input  logic            free_vld_i,
  input  logic [PW-1:0]   free_preg_i,
  output logic [PW:0]     free_cnt_o,
  output logic            free_err_o
);

  localparam int FL_DEPTH = PHYS_REG_NUM - 32;
  localparam int FW       = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_ALLOC, S_OUT} state_t;
  state_t state, state_nxt;

  logic [4:0] vs1_q, vs2_q, vd_q;
  logic [1:0] lmul_q;
  logic       wr_q;
  logic [2:0] k_q;
  logic [3:0] grp_n;
  logic       last_slot;
  logic       pop;
  logic [PW-1:0] pop_preg;

  assign grp_n     = 4'd1 << lmul_q;
  assign last_slot = ({1'b0, k_q} == (grp_n - 4'd1));

  function automatic logic [AW-1:0] base_addr(input logic [PW-1:0] p);
    return AW'(p) * AW'(LP_VECTOR_REG_SIZE);
  endfunction

`ifndef RENAME_BYPASS_EN
  logic [PW-1:0] map_q [32];
  logic [PW-1:0] fl_mem [FL_DEPTH];
  logic [FW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt_q;
  logic          fl_empty, fl_full, pass_thru, push, pop_mem;

  function automatic logic [PW-1:0] map_rd(input logic [4:0] idx);
    return map_q[idx];
  endfunction

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == FW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fl_empty  = (cnt_q == '0);
  assign fl_full   = (cnt_q == (PW+1)'(FL_DEPTH));
  assign pop       = (state == S_ALLOC) && (!fl_empty || free_vld_i);
  // Empty list with a simultaneous push: the pushed preg is handed straight
  // to the allocator and the storage is left untouched.
  assign pass_thru = fl_empty && free_vld_i && (state == S_ALLOC);
  assign pop_mem   = pop && !pass_thru;
  // A pop in the same cycle frees the slot a full-list push needs.
  assign push      = free_vld_i && (!fl_full || pop) && !pass_thru;
  assign pop_preg  = fl_empty ? free_preg_i : fl_mem[rd_ptr];
  assign free_cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl_mem[i] <= PW'(32 + i);
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt_q      <= (PW+1)'(FL_DEPTH);
      free_err_o <= 1'b0;
    end else begin
      free_err_o <= free_vld_i && fl_full && !pop;
      if (pop) map_q[5'(vd_q + 5'(k_q))] <= pop_preg;
      if (push) begin
        fl_mem[wr_ptr] <= free_preg_i;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop_mem) rd_ptr <= ptr_inc(rd_ptr);
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop_mem);
    end
  end
`else
  logic unused_free;
  assign unused_free = ^{free_vld_i, free_preg_i};

  function automatic logic [PW-1:0] map_rd(input logic [4:0] idx);
    return PW'(idx);
  endfunction

  assign pop        = 1'b0;
  assign pop_preg   = '0;
  assign free_cnt_o = '0;
  assign free_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt               = state;
    instr_rdy_o             = 1'b0;
    vrf_starting_addr_vld_o = 1'b0;
    case (state)
      S_IDLE: begin
        instr_rdy_o = 1'b1;
        if (instr_vld_i) state_nxt = S_READ;
      end
      S_READ: begin
`ifdef RENAME_BYPASS_EN
        state_nxt = S_OUT;
`else
        state_nxt = wr_q ? S_ALLOC : S_OUT;
`endif
      end
      S_ALLOC: if (pop && last_slot) state_nxt = S_OUT;
      S_OUT: begin
        vrf_starting_addr_vld_o = 1'b1;
        if (vrf_starting_addr_rdy_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs1_q  <= '0;
      vs2_q  <= '0;
      vd_q   <= '0;
      lmul_q <= '0;
      wr_q   <= 1'b0;
      k_q    <= '0;
      vrf_starting_raddr0_o <= '0;
      vrf_starting_raddr1_o <= '0;
      vrf_starting_waddr_o  <= '0;
      old_preg_o            <= '0;
    end else begin
      case (state)
        S_IDLE: if (instr_vld_i) begin
          vs1_q  <= vs1_i;
          vs2_q  <= vs2_i;
          vd_q   <= vd_i;
          lmul_q <= lmul_i;
          wr_q   <= vd_wr_i;
          k_q    <= '0;
          vrf_starting_raddr0_o <= '0;
          vrf_starting_raddr1_o <= '0;
          vrf_starting_waddr_o  <= '0;
          old_preg_o            <= '0;
        end
        S_READ: begin
          for (int k = 0; k < 8; k++) begin
            if (k < int'(grp_n)) begin
              vrf_starting_raddr0_o[k*AW +: AW] <= base_addr(map_rd(5'(vs1_q + 5'(k))));
              vrf_starting_raddr1_o[k*AW +: AW] <= base_addr(map_rd(5'(vs2_q + 5'(k))));
              if (wr_q) begin
`ifdef RENAME_BYPASS_EN
                vrf_starting_waddr_o[k*AW +: AW] <= base_addr(map_rd(5'(vd_q + 5'(k))));
`else
                old_preg_o[k*PW +: PW] <= map_rd(5'(vd_q + 5'(k)));
`endif
              end
            end
          end
        end
        S_ALLOC: if (pop) begin
          vrf_starting_waddr_o[int'(k_q)*AW +: AW] <= base_addr(pop_preg);
          k_q <= k_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
